hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//   Parametrised RAW-hazard and structural-hazard controller for the 5-stage pipeline.
//   Compares ID-stage source registers against EX/MEM destination registers.
//   Produces a registered stall request for the PC/IF-ID/ID-EX control.
//   Optionally produces forwarding selects (FWD_EN=1); then stalls only on load-use.
//   Also stalls ID while the multi-cycle multiply/divide unit (MDU) is busy.
// PARAMETERS
//   ADDR_W       5   register address width
//   FWD_EN       0   0: stall-only hazard resolution; 1: forwarding, stall on load-use only
//   EX_STALL     2   stall cycles on an EX-stage match (FWD_EN=0), range 1..7
//   MEM_STALL    1   stall cycles on a MEM-stage match (FWD_EN=0), range 1..7
//   LOAD_STALL   1   stall cycles on an EX-stage load-use match (FWD_EN=1), range 1..7
//   ZERO_EXEMPT  1   1: register address 0 never produces a hazard or a forward
//   MDU_CYCLES   4   busy cycles after an MDU start, range 1..63
// PORTS
//   in_clk        in   1       clock; all state updates on the FALLING edge
//   in_rst        in   1       asynchronous reset, active-high
//   in_rs_addr    in   ADDR_W  ID source register rs
//   in_rt_addr    in   ADDR_W  ID source register rt
//   in_rs_rena    in   1       ID instruction reads rs
//   in_rt_rena    in   1       ID instruction reads rt
//   in_ex_wena    in   1       EX instruction writes the register file
//   in_ex_waddr   in   ADDR_W  EX destination register
//   in_ex_is_load in   1       EX instruction is a load
//   in_mem_wena   in   1       MEM instruction writes the register file
//   in_mem_waddr  in   ADDR_W  MEM destination register
//   in_mdu_start  in   1       one-cycle pulse: EX issues a multiply/divide
//   in_id_mdu_op  in   1       ID instruction reads HI/LO or issues an MDU op
//   out_stall     out  1       registered stall request (freeze PC/IF-ID, bubble ID-EX)
//   out_fwd_rs    out  2       rs source: 00 regfile, 01 EX result, 10 MEM result; combinational
//   out_fwd_rt    out  2       rt source, same encoding as out_fwd_rs
//   out_mdu_busy  out  1       registered; high while the MDU counter is nonzero
// BEHAVIOUR
//   Definitions:
//     match_ex(s) = s_rena & in_ex_wena & (in_ex_waddr==s_addr) & !(ZERO_EXEMPT & s_addr==0)
//     match_mem(s) is the same, using the MEM stage ports.
//   Reset (async, in_rst=1):
//     out_stall=1; rem=0; mdu_cnt=0; out_mdu_busy=0.
//     Gives one start-up bubble: out_stall falls at the first falling edge after release
//     if no hazard is present.
//   State: rem = 3-bit remaining-stall counter; mdu_cnt = 6-bit MDU busy counter.
//   Each falling edge, stall logic, in priority order:
//     1. rem!=0: rem<=rem-1, out_stall<=1. Inputs are ignored.
//     2. rem==0 and a hazard of length L is present: out_stall<=1, rem<=L-1.
//     3. Otherwise: out_stall<=0.
//   Hazard length L:
//     FWD_EN=0: any match_ex gives L=EX_STALL (EX beats MEM); else any match_mem gives L=MEM_STALL.
//     FWD_EN=1: in_ex_is_load & any match_ex gives L=LOAD_STALL.
//               Non-load EX matches and all MEM matches give no stall.
//     MDU hazard: in_id_mdu_op & (mdu_cnt!=0) gives L=1.
//       It is re-evaluated each edge, so the stall holds until the MDU is idle.
//     Several hazards at once: L = the maximum of the applicable values.
//   MDU counter, each falling edge:
//     in_mdu_start=1: mdu_cnt<=MDU_CYCLES. A start while busy restarts the count.
//     Otherwise, if mdu_cnt!=0: mdu_cnt<=mdu_cnt-1.
//     out_mdu_busy <= (next mdu_cnt != 0).
//   Forwarding (FWD_EN=1):
//     out_fwd_x = 01 if match_ex(x) & !in_ex_is_load; else 10 if match_mem(x); else 00.
//     EX takes priority over MEM for the same register.
//     FWD_EN=0: out_fwd_rs and out_fwd_rt are tied to 00.
//   rena=0 for a source suppresses both stall and forward for that source.
//   Reset asserted mid-stall or mid-MDU count clears all state immediately.
// TESTING
//   1. Reset held, then released with no hazards: out_stall=1 during reset; 0 after the first falling edge.
//   2. FWD_EN=0, rs_rena=1, rs=8, ex_wena=1, ex_waddr=8: out_stall high exactly 2 cycles, then inputs re-evaluated.
//   3. FWD_EN=0, rt=9 matches MEM only: 1-cycle stall. rs matches EX while rt matches MEM: 2-cycle stall.
//   4. ZERO_EXEMPT=1, rs=0, ex_waddr=0, ex_wena=1: no stall, fwd=00. With ZERO_EXEMPT=0: 2-cycle stall.
//   5. FWD_EN=1, EX ALU op writes r5, ID reads rs=r5: no stall, out_fwd_rs=01.
//      Same case with in_ex_is_load=1: 1-cycle stall. MEM writes r5: out_fwd_rs=10.
//   6. MDU_CYCLES=4: start pulse, then id_mdu_op=1: stall while out_mdu_busy=1 (4 edges).
//      in_rst pulsed at count 2: busy and stall clear immediately.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline.
// Stalls ID on RAW and busy-MDU hazards, and optionally selects forwarding sources.
module hazard_ctrl #(
    parameter int ADDR_W      = 5,
    parameter int FWD_EN      = 0,
    parameter int EX_STALL    = 2,
    parameter int MEM_STALL   = 1,
    parameter int LOAD_STALL  = 1,
    parameter int ZERO_EXEMPT = 1,
    parameter int MDU_CYCLES  = 4
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic [ADDR_W-1:0] in_rs_addr,
    input  logic [ADDR_W-1:0] in_rt_addr,
    input  logic              in_rs_rena,
    input  logic              in_rt_rena,
    input  logic              in_ex_wena,
    input  logic [ADDR_W-1:0] in_ex_waddr,
    input  logic              in_ex_is_load,
    input  logic              in_mem_wena,
    input  logic [ADDR_W-1:0] in_mem_waddr,
    input  logic              in_mdu_start,
    input  logic              in_id_mdu_op,
    output logic              out_stall,
    output logic [1:0]        out_fwd_rs,
    output logic [1:0]        out_fwd_rt,
    output logic              out_mdu_busy
);

    localparam logic [2:0] EX_LEN   = 3'(EX_STALL);
    localparam logic [2:0] MEM_LEN  = 3'(MEM_STALL);
    localparam logic [2:0] LOAD_LEN = 3'(LOAD_STALL);
    localparam logic [5:0] MDU_LEN  = 6'(MDU_CYCLES);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic [2:0] rem;
    logic [5:0] mdu_cnt;
    logic [5:0] mdu_cnt_next;
    logic       ex_rs, ex_rt, mem_rs, mem_rt;
    logic [2:0] len_data, len_mdu, hazard_len;

    // A source only conflicts with a writer when it is actually read and is not r0 (if exempt).
    function automatic logic src_match(input logic              rena,
                                       input logic [ADDR_W-1:0] s_addr,
                                       input logic              wena,
                                       input logic [ADDR_W-1:0] waddr);
        return rena && wena && (waddr == s_addr) &&
               !((ZERO_EXEMPT != 0) && (s_addr == '0));
    endfunction

    assign ex_rs  = src_match(in_rs_rena, in_rs_addr, in_ex_wena,  in_ex_waddr);
    assign ex_rt  = src_match(in_rt_rena, in_rt_addr, in_ex_wena,  in_ex_waddr);
    assign mem_rs = src_match(in_rs_rena, in_rs_addr, in_mem_wena, in_mem_waddr);
    assign mem_rt = src_match(in_rt_rena, in_rt_addr, in_mem_wena, in_mem_waddr);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        len_data = 3'd0;
        if (FWD_EN == 0) begin
            if (ex_rs || ex_rt)
                len_data = EX_LEN;
            else if (mem_rs || mem_rt)
                len_data = MEM_LEN;
        end else if (in_ex_is_load && (ex_rs || ex_rt)) begin
            len_data = LOAD_LEN;
        end
        len_mdu    = (in_id_mdu_op && (mdu_cnt != 6'd0)) ? 3'd1 : 3'd0;
        hazard_len = (len_data > len_mdu) ? len_data : len_mdu;
    end

    // EX result beats MEM result for the same register; a load in EX cannot forward yet.
    always_comb begin
        out_fwd_rs = FWD_RF;
        out_fwd_rt = FWD_RF;
        if (FWD_EN != 0) begin
            if (ex_rs && !in_ex_is_load)
                out_fwd_rs = FWD_EX;
            else if (mem_rs)
                out_fwd_rs = FWD_MEM;
            if (ex_rt && !in_ex_is_load)
                out_fwd_rt = FWD_EX;
            else if (mem_rt)
                out_fwd_rt = FWD_MEM;
        end
    end

    always_comb begin
        mdu_cnt_next = mdu_cnt;
        if (in_mdu_start)
            mdu_cnt_next = MDU_LEN;
        else if (mdu_cnt != 6'd0)
            mdu_cnt_next = mdu_cnt - 6'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample the same edge.
    always_ff @(negedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            out_stall    <= 1'b1;
            rem          <= 3'd0;
            mdu_cnt      <= 6'd0;
            out_mdu_busy <= 1'b0;
        end else begin
            mdu_cnt      <= mdu_cnt_next;
            out_mdu_busy <= (mdu_cnt_next != 6'd0);
            // A running stall ignores the inputs until it has fully drained.
            if (rem != 3'd0) begin
                rem       <= rem - 3'd1;
                out_stall <= 1'b1;
            end else if (hazard_len != 3'd0) begin
                rem       <= hazard_len - 3'd1;
                out_stall <= 1'b1;
            end else begin
                out_stall <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: three configurations share one directed stimulus stream.
// A: stall-only, r0 exempt.  B: forwarding, r0 exempt.  C: stall-only, r0 not exempt.
module tb_hazard_ctrl;

    typedef struct {
        string      name;
        logic [1:0] sa, sb, sc, busy, frs, frt;
    } exp_t;

    logic       clk = 1'b1;
    logic       rst;
    logic [4:0] rs_addr, rt_addr, ex_waddr, mem_waddr;
    logic       rs_rena, rt_rena, ex_wena, ex_is_load, mem_wena, mdu_start, id_mdu_op;

    logic       stall_a, stall_b, stall_c, busy_a, busy_b, busy_c;
    logic [1:0] fwd_rs_a, fwd_rt_a, fwd_rs_b, fwd_rt_b, fwd_rs_c, fwd_rt_c;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FWD_EN(0), .ZERO_EXEMPT(1)) u_dut_a (
        .in_clk(clk), .in_rst(rst), .in_rs_addr(rs_addr), .in_rt_addr(rt_addr),
        .in_rs_rena(rs_rena), .in_rt_rena(rt_rena), .in_ex_wena(ex_wena),
        .in_ex_waddr(ex_waddr), .in_ex_is_load(ex_is_load), .in_mem_wena(mem_wena),
        .in_mem_waddr(mem_waddr), .in_mdu_start(mdu_start), .in_id_mdu_op(id_mdu_op),
        .out_stall(stall_a), .out_fwd_rs(fwd_rs_a), .out_fwd_rt(fwd_rt_a), .out_mdu_busy(busy_a)
    );

    hazard_ctrl #(.FWD_EN(1), .ZERO_EXEMPT(1)) u_dut_b (
        .in_clk(clk), .in_rst(rst), .in_rs_addr(rs_addr), .in_rt_addr(rt_addr),
        .in_rs_rena(rs_rena), .in_rt_rena(rt_rena), .in_ex_wena(ex_wena),
        .in_ex_waddr(ex_waddr), .in_ex_is_load(ex_is_load), .in_mem_wena(mem_wena),
        .in_mem_waddr(mem_waddr), .in_mdu_start(mdu_start), .in_id_mdu_op(id_mdu_op),
        .out_stall(stall_b), .out_fwd_rs(fwd_rs_b), .out_fwd_rt(fwd_rt_b), .out_mdu_busy(busy_b)
    );

    hazard_ctrl #(.FWD_EN(0), .ZERO_EXEMPT(0)) u_dut_c (
        .in_clk(clk), .in_rst(rst), .in_rs_addr(rs_addr), .in_rt_addr(rt_addr),
        .in_rs_rena(rs_rena), .in_rt_rena(rt_rena), .in_ex_wena(ex_wena),
        .in_ex_waddr(ex_waddr), .in_ex_is_load(ex_is_load), .in_mem_wena(mem_wena),
        .in_mem_waddr(mem_waddr), .in_mdu_start(mdu_start), .in_id_mdu_op(id_mdu_op),
        .out_stall(stall_c), .out_fwd_rs(fwd_rs_c), .out_fwd_rt(fwd_rt_c), .out_mdu_busy(busy_c)
    );

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs at the rising edge; the falling edge then updates the DUTs.
    task automatic step(input string name, input logic r,
                        input logic [4:0] rs, input logic rse, input logic [4:0] rt, input logic rte,
                        input logic exwe, input logic [4:0] exwa, input logic ld,
                        input logic mwe, input logic [4:0] mwa, input logic st, input logic op,
                        input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] sc,
                        input logic [1:0] busy, input logic [1:0] frs, input logic [1:0] frt);
        exp_t e;
        @(posedge clk);
        rst = r; rs_addr = rs; rs_rena = rse; rt_addr = rt; rt_rena = rte;
        ex_wena = exwe; ex_waddr = exwa; ex_is_load = ld;
        mem_wena = mwe; mem_waddr = mwa; mdu_start = st; id_mdu_op = op;
        e.name = name; e.sa = sa; e.sb = sb; e.sc = sc; e.busy = busy; e.frs = frs; e.frt = frt;
        sb_q.push_back(e);
        if (r) begin
            // Reset must take effect without waiting for a clock edge.
            #1;
            check({name, ".async_busy_a"},  2'(busy_a),  2'd0);
            check({name, ".async_busy_b"},  2'(busy_b),  2'd0);
            check({name, ".async_stall_a"}, 2'(stall_a), 2'd1);
            check({name, ".async_stall_c"}, 2'(stall_c), 2'd1);
        end
    endtask

    task automatic idle(input string name, input logic [1:0] sa, input logic [1:0] sb,
                        input logic [1:0] sc, input logic [1:0] busy);
        step(name, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, sa, sb, sc, busy, 0, 0);
    endtask

    // Monitor: registered outputs are settled just after each falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({e.name, ".stall_a"},  2'(stall_a), e.sa);
                check({e.name, ".stall_b"},  2'(stall_b), e.sb);
                check({e.name, ".stall_c"},  2'(stall_c), e.sc);
                check({e.name, ".busy_a"},   2'(busy_a),  e.busy);
                check({e.name, ".busy_b"},   2'(busy_b),  e.busy);
                check({e.name, ".busy_c"},   2'(busy_c),  e.busy);
                check({e.name, ".fwd_rs_b"}, fwd_rs_b,    e.frs);
                check({e.name, ".fwd_rt_b"}, fwd_rt_b,    e.frt);
                check({e.name, ".fwd_a"},    fwd_rs_a | fwd_rt_a, 2'd0);
                check({e.name, ".fwd_c"},    fwd_rs_c | fwd_rt_c, 2'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int left;
        rst = 1'b1; rs_addr = 5'd1; rt_addr = 5'd2; rs_rena = 0; rt_rena = 0;
        ex_wena = 0; ex_waddr = 0; ex_is_load = 0; mem_wena = 0; mem_waddr = 0;
        mdu_start = 0; id_mdu_op = 0;

        //    name           rst rs rse rt rte exwe exwa ld mwe mwa st op   sa sb sc busy frs frt
        step("reset",         1, 1, 0, 2, 0,   0,  0,  0,  0,  0, 0, 0,   1, 1, 1, 0,   0, 0);
        step("release",       0, 1, 0, 2, 0,   0,  0,  0,  0,  0, 0, 0,   0, 0, 0, 0,   0, 0);
        step("ex_rs8",        0, 8, 1, 2, 0,   1,  8,  0,  0,  0, 0, 0,   1, 0, 1, 0,   1, 0);
        idle("ex_rs8_hold",   1, 0, 1, 0);
        idle("ex_rs8_done",   0, 0, 0, 0);
        step("mem_rt9",       0, 1, 0, 9, 1,   0,  0,  0,  1,  9, 0, 0,   1, 0, 1, 0,   0, 2);
        idle("mem_rt9_done",  0, 0, 0, 0);
        step("ex_rs_mem_rt",  0, 8, 1, 9, 1,   1,  8,  0,  1,  9, 0, 0,   1, 0, 1, 0,   1, 2);
        idle("mix_hold",      1, 0, 1, 0);
        idle("mix_done",      0, 0, 0, 0);
        step("zero_reg",      0, 0, 1, 2, 0,   1,  0,  0,  0,  0, 0, 0,   0, 0, 1, 0,   0, 0);
        idle("zero_hold",     0, 0, 1, 0);
        idle("zero_done",     0, 0, 0, 0);
        step("alu_r5",        0, 5, 1, 2, 0,   1,  5,  0,  0,  0, 0, 0,   1, 0, 1, 0,   1, 0);
        step("load_r5",       0, 5, 1, 2, 0,   1,  5,  1,  0,  0, 0, 0,   1, 1, 1, 0,   0, 0);
        step("mem_r5",        0, 5, 1, 2, 0,   0,  0,  0,  1,  5, 0, 0,   1, 0, 1, 0,   2, 0);
        idle("r5_done",       0, 0, 0, 0);
        step("ex_over_mem",   0, 5, 1, 2, 0,   1,  5,  0,  1,  5, 0, 0,   1, 0, 1, 0,   1, 0);
        idle("eom_hold",      1, 0, 1, 0);
        idle("eom_done",      0, 0, 0, 0);
        step("rena_off",      0, 7, 0, 7, 0,   1,  7,  1,  0,  0, 0, 0,   0, 0, 0, 0,   0, 0);
        step("mdu_start",     0, 1, 0, 2, 0,   0,  0,  0,  0,  0, 1, 0,   0, 0, 0, 1,   0, 0);
        step("mdu_wait1",     0, 1, 0, 2, 0,   0,  0,  0,  0,  0, 0, 1,   1, 1, 1, 1,   0, 0);
        step("mdu_wait2",     0, 1, 0, 2, 0,   0,  0,  0,  0,  0, 0, 1,   1, 1, 1, 1,   0, 0);
        step("mdu_wait3",     0, 1, 0, 2, 0,   0,  0,  0,  0,  0, 0, 1,   1, 1, 1, 1,   0, 0);
        step("mdu_wait4",     0, 1, 0, 2, 0,   0,  0,  0,  0,  0, 0, 1,   1, 1, 1, 0,   0, 0);
        step("mdu_idle",      0, 1, 0, 2, 0,   0,  0,  0,  0,  0, 0, 1,   0, 0, 0, 0,   0, 0);
        step("mdu_start2",    0, 1, 0, 2, 0,   0,  0,  0,  0,  0, 1, 0,   0, 0, 0, 1,   0, 0);
        idle("mdu_cnt3",      0, 0, 0, 1);
        idle("mdu_cnt2",      0, 0, 0, 1);
        step("mdu_restart",   0, 1, 0, 2, 0,   0,  0,  0,  0,  0, 1, 0,   0, 0, 0, 1,   0, 0);
        idle("restart_cnt3",  0, 0, 0, 1);
        idle("restart_cnt2",  0, 0, 0, 1);
        idle("restart_cnt1",  0, 0, 0, 1);
        idle("restart_cnt0",  0, 0, 0, 0);
        step("mdu_start3",    0, 1, 0, 2, 0,   0,  0,  0,  0,  0, 1, 0,   0, 0, 0, 1,   0, 0);
        step("mdu_op_cnt3",   0, 1, 0, 2, 0,   0,  0,  0,  0,  0, 0, 1,   1, 1, 1, 1,   0, 0);
        step("mdu_plus_ex",   0, 8, 1, 2, 0,   1,  8,  0,  0,  0, 0, 1,   1, 1, 1, 1,   1, 0);
        step("reset_mid",     1, 1, 0, 2, 0,   0,  0,  0,  0,  0, 0, 0,   1, 1, 1, 0,   0, 0);
        step("after_reset",   0, 1, 0, 2, 0,   0,  0,  0,  0,  0, 0, 1,   0, 0, 0, 0,   0, 0);
        idle("final_idle",    0, 0, 0, 0);

        for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
        #2;
        left = sb_q.size();
        check("sb_drain", (left > 3) ? 2'd3 : 2'(left), 2'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
